fetch_ctrl: RTL

Fetch sequencer that drives the PC register's control inputs (`i_jump`, `i_jump_address`, `i_stall`, `i_halt`) and owns the instruction-memory request handshake. It sits between the PC, instruction memory and the decode stage.
- Advances the PC exactly once per accepted fetch.
- Applies execute-stage redirects.
- Holds one fetched instruction for decode.
- Sequences the processor into a terminal halt.

---
 rtl/fetch_ctrl_pkg.sv | 13 +
 rtl/fetch_ctrl.sv | 116 +++++++++++
 2 files changed

// File: rtl/fetch_ctrl_pkg.sv
// Shared definitions for the fetch sequencer: state encoding and default width.
package fetch_ctrl_pkg;

   localparam int XLEN_DEFAULT = 32;

   typedef enum logic [1:0] {
      ST_BOOT    = 2'd0,
      ST_RUN     = 2'd1,
      ST_HALTING = 2'd2,
      ST_HALTED  = 2'd3
   } state_t;

endpackage

// File: rtl/fetch_ctrl.sv
// Fetch sequencer: drives the PC control inputs, owns the instruction-memory
// request handshake and holds one fetched instruction for decode.
//
// Handshakes: a memory transfer completes in any cycle where o_imem_req and
// i_imem_ack are both high ("fire"); decode takes the held instruction in any
// cycle where o_instr_valid and i_dec_ready are both high. Dropping o_imem_req
// without an ack leaves nothing pending.
module fetch_ctrl
   import fetch_ctrl_pkg::*;
#(
   parameter int XLEN        = XLEN_DEFAULT,
   parameter int BOOT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            i_reset,
   input  logic [XLEN-1:0] i_pc,
   output logic            o_pc_jump,
   output logic [XLEN-1:0] o_pc_jump_address,
   output logic            o_pc_stall,
   output logic            o_pc_halt,
   output logic            o_imem_req,
   output logic [XLEN-1:0] o_imem_addr,
   input  logic            i_imem_ack,
   input  logic [XLEN-1:0] i_imem_rdata,
   output logic [XLEN-1:0] o_instr,
   output logic [XLEN-1:0] o_instr_pc,
   output logic            o_instr_valid,
   input  logic            i_dec_ready,
   input  logic            i_redirect,
   input  logic [XLEN-1:0] i_redirect_addr,
   input  logic            i_halt_req,
   output logic            o_halted,
   output logic [31:0]     o_fetch_count
);

   localparam int CW = (BOOT_CYCLES > 1) ? $clog2(BOOT_CYCLES) : 1;

   state_t          state;
   state_t          state_next;
   logic [CW-1:0]   boot_cnt;
   logic            fire;
   logic            consume;
   logic            in_flow;

   // In RUN/HALTING a redirect is honoured; elsewhere it is ignored.
   assign in_flow           = (state == ST_RUN) || (state == ST_HALTING);
   assign o_pc_jump         = i_redirect && in_flow;
   assign o_pc_jump_address = i_redirect_addr;
   // A redirect suppresses the request so a same-cycle ack can never land.
   assign o_imem_req        = (state == ST_RUN) && !i_redirect &&
                              (!o_instr_valid || i_dec_ready);
   assign o_imem_addr       = i_pc;
   assign fire              = o_imem_req && i_imem_ack;
   assign consume           = o_instr_valid && i_dec_ready;
   // The PC only moves on an accepted fetch or a redirect.
   assign o_pc_stall        = !(fire || o_pc_jump);
   assign o_pc_halt         = (state == ST_HALTED);
   assign o_halted          = (state == ST_HALTED);

   // State register and boot down-counter.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         state    <= ST_BOOT;
         boot_cnt <= CW'(BOOT_CYCLES - 1);
      end else begin
         state <= state_next;
         if (state == ST_BOOT && boot_cnt != '0) begin
            boot_cnt <= boot_cnt - CW'(1);
         end
      end
   end

   // Next-state selection; redirect outranks halt on a simultaneous event.
   always_comb begin
      state_next = state;
      case (state)
         ST_BOOT: begin
            if (boot_cnt == '0) state_next = ST_RUN;
         end
         ST_RUN: begin
            if (!i_redirect && i_halt_req) state_next = ST_HALTING;
         end
         ST_HALTING: begin
            if (i_redirect) begin
               state_next = ST_RUN;
            end else if (!o_instr_valid || consume) begin
               state_next = ST_HALTED;
            end
         end
         ST_HALTED: begin
            state_next = ST_HALTED;
         end
         default: state_next = ST_BOOT;
      endcase
   end

   // Instruction holding register and accepted-fetch counter.
   always_ff @(posedge clk) begin
      if (i_reset) begin
         o_instr       <= '0;
         o_instr_pc    <= '0;
         o_instr_valid <= 1'b0;
         o_fetch_count <= 32'd0;
      end else if (o_pc_jump) begin
         o_instr_valid <= 1'b0;
      end else if (fire) begin
         o_instr       <= i_imem_rdata;
         o_instr_pc    <= i_pc;
         o_instr_valid <= 1'b1;
         o_fetch_count <= o_fetch_count + 32'd1;
      end else if (consume) begin
         o_instr_valid <= 1'b0;
      end
   end

endmodule
